f7_06_op_sweeper: RTL and testbench
===================================

// Module: f7_06_op_sweeper
// PURPOSE
//  Upstream sequencer for the f7_05 1-bit logic unit (AND/OR/NAND/NOR/XOR/XNOR, 3-bit one-hot-free select).
//  On start it latches one operand pair and drives it with select codes 0..NUM_OPS-1, one per cycle.
//  It samples the unit's combinational result into a result vector, one bit per op, then pulses done.
//  Result bit i holds the unit's output for select code i. Used to sweep all ops for a given x,y pair.
// PARAMETERS
//  NUM_OPS  6  number of select codes swept (legal 1..8); code i -> sel_02,sel_01,sel_00 = i[2:0]
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        request a sweep; sampled only in IDLE
//  a_in       in   1        operand a, captured on accepted start
//  b_in       in   1        operand b, captured on accepted start
//  op_a       out  1        registered operand a to logic unit
//  op_b       out  1        registered operand b to logic unit
//  sel_00     out  1        select bit 0 to logic unit
//  sel_01     out  1        select bit 1 to logic unit
//  sel_02     out  1        select bit 2 to logic unit
//  lu_result  in   1        combinational output s of logic unit
//  busy       out  1        high while a sweep is in progress (RUN state)
//  done       out  1        one-cycle pulse after last result bit captured
//  result     out  NUM_OPS  captured results; bit i = op code i; held until next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, async, any state): state=IDLE, op_a=op_b=0, sel=000, idx=0, busy=0, done=0, result=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: sel=000. On a clk edge with start=1: op_a<=a_in, op_b<=b_in, idx<=0, result<=0, go RUN.
//   start=0: stay IDLE, all outputs hold (result keeps last sweep).
//  RUN: busy=1; {sel_02,sel_01,sel_00}=idx[2:0] (registered, glitch-free). Every edge: result[idx]<=lu_result.
//   If idx==NUM_OPS-1 go DONE, else idx<=idx+1. start and a_in/b_in ignored; op_a/op_b stable.
//  DONE: busy=0, done=1 for exactly this cycle, sel=000; next edge go IDLE unconditionally.
//   start asserted in DONE is ignored (not queued); must be re-presented in IDLE.
//  Latency: start sampled at edge E0 -> RUN cycles E0..E0+NUM_OPS-1 -> done high in cycle after edge E0+NUM_OPS.
//   Total start-to-done = NUM_OPS+1 cycles; back-to-back sweep period = NUM_OPS+2 cycles.
//  Codes 6,7 (NUM_OPS>6): logic unit outputs 0; result bits capture 0; no special handling.
//  idx width = 3 bits; never wraps past NUM_OPS-1. No X may propagate to result from a reset state.
//  Reset asserted mid-RUN: sweep aborted, no done pulse, result cleared to 0.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> busy=0, done=0, result=6'b000000, sel=000, op_a=op_b=0.
//  2 a_in=0,b_in=1, start 1 cycle -> sel steps 000..101 on 6 consecutive cycles; done pulse 7 cycles
//    after start edge; result=6'b010110.
//  3 Sweeps with (1,1)->6'b100011, (1,0)->6'b010110, (0,0)->6'b101100; result stable while IDLE.
//  4 Toggle a_in/b_in and pulse start during RUN and in DONE cycle -> no effect; op_a/op_b unchanged,
//    exactly one done pulse, no second sweep started.
//  5 Assert rst_n=0 on 3rd RUN cycle -> outputs immediately at reset values, no done; next start runs clean.
//  6 NUM_OPS=8, a=1,b=1 -> sel reaches 111; done after 9 cycles; result=8'b00100011.

Source files
------------

// File: rtl/f7_06_op_sweeper_if.sv
// Bundle between the op sweeper, its requester and the 1-bit logic unit it drives.
// The master side (requester plus logic unit) drives start, the operands and lu_result.
// The slave side (the sweeper) drives the operand, select, status and result lines.
interface f7_06_op_sweeper_if #(
   parameter int NUM_OPS = 6
);
   logic               start;
   logic               a_in;
   logic               b_in;
   logic               op_a;
   logic               op_b;
   logic               sel_00;
   logic               sel_01;
   logic               sel_02;
   logic               lu_result;
   logic               busy;
   logic               done;
   logic [NUM_OPS-1:0] result;

   modport master (
      output start, a_in, b_in, lu_result,
      input  op_a, op_b, sel_00, sel_01, sel_02, busy, done, result
   );

   modport slave (
      input  start, a_in, b_in, lu_result,
      output op_a, op_b, sel_00, sel_01, sel_02, busy, done, result
   );
endinterface

// File: rtl/f7_06_op_sweeper.sv
// Sweeps one latched operand pair through select codes 0..NUM_OPS-1 of the
// f7_05 logic unit and collects one result bit per code, then pulses done.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; select held at 000, result held
//   S_RUN  | one select code per cycle; lu_result captured into result[idx]
//   S_DONE | single-cycle done pulse; start is ignored here
//
// The select lines come straight from idx_q, which is parked at 0 outside
// S_RUN, so the logic unit sees a glitch-free registered code.
module f7_06_op_sweeper #(
   parameter int NUM_OPS = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   f7_06_op_sweeper_if.slave      sw
);

   localparam logic [2:0] IDX_LAST = 3'(NUM_OPS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         idx_q, idx_d;
   logic               op_a_q, op_a_d;
   logic               op_b_q, op_b_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [NUM_OPS-1:0] result_q, result_d;

   // State and datapath registers; reset aborts any sweep and clears the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= 3'd0;
         op_a_q   <= 1'b0;
         op_b_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // Next-state and next-output logic; busy/done are registered from the next state.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      result_d = result_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sw.start) begin
               op_a_d   = sw.a_in;
               op_b_d   = sw.b_in;
               idx_d    = 3'd0;
               result_d = '0;
               busy_d   = 1'b1;
               state_d  = S_RUN;
            end
         end

         S_RUN: begin
            for (int i = 0; i < NUM_OPS; i++) begin
               if (idx_q == 3'(i)) begin
                  result_d[i] = sw.lu_result;
               end
            end
            if (idx_q == IDX_LAST) begin
               idx_d   = 3'd0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               idx_d  = idx_q + 3'd1;
               busy_d = 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            idx_d   = 3'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign sw.op_a   = op_a_q;
   assign sw.op_b   = op_b_q;
   assign sw.sel_00 = idx_q[0];
   assign sw.sel_01 = idx_q[1];
   assign sw.sel_02 = idx_q[2];
   assign sw.busy   = busy_q;
   assign sw.done   = done_q;
   assign sw.result = result_q;

endmodule

// File: tb/tb_f7_06_op_sweeper.sv
// Bench for the op sweeper: a 6-op and an 8-op instance, each driving a
// behavioural f7_05 logic unit. Expected result vectors are queued when a
// sweep is launched and checked when done pulses.
module tb_f7_06_op_sweeper;

   logic clk;
   logic rst_n;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt6 = 0;
   int done_cnt8 = 0;

   logic [7:0] q6[$];
   logic [7:0] q8[$];

   f7_06_op_sweeper_if #(.NUM_OPS(6)) if6 ();
   f7_06_op_sweeper_if #(.NUM_OPS(8)) if8 ();

   f7_06_op_sweeper #(.NUM_OPS(6)) dut6 (.clk(clk), .rst_n(rst_n), .sw(if6.slave));
   f7_06_op_sweeper #(.NUM_OPS(8)) dut8 (.clk(clk), .rst_n(rst_n), .sw(if8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // f7_05 logic unit: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 -> 0
   function automatic logic lu_fn(input logic a, input logic b, input logic [2:0] code);
      case (code)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return ~(a & b);
         3'd3: return ~(a | b);
         3'd4: return a ^ b;
         3'd5: return ~(a ^ b);
         default: return 1'b0;
      endcase
   endfunction

   assign if6.lu_result = lu_fn(if6.op_a, if6.op_b, {if6.sel_02, if6.sel_01, if6.sel_00});
   assign if8.lu_result = lu_fn(if8.op_a, if8.op_b, {if8.sel_02, if8.sel_01, if8.sel_00});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboards: pop the expected vector whenever done pulses.
   always @(negedge clk) begin
      if (rst_n && if6.done) begin
         done_cnt6++;
         if (q6.size() == 0) chk("sb6_unexpected_done", 32'd1, 32'd0);
         else chk("sb6_result", 32'(if6.result), 32'(q6.pop_front()));
      end
      if (rst_n && if8.done) begin
         done_cnt8++;
         if (q8.size() == 0) chk("sb8_unexpected_done", 32'd1, 32'd0);
         else chk("sb8_result", 32'(if8.result), 32'(q8.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Launch a sweep on the 6-op instance and check every cycle up to the end of DONE.
   // With disturb set, operands and start are toggled during RUN and start is held in DONE.
   task automatic sweep6(input logic a, input logic b, input logic [7:0] exp, input bit disturb);
      int d0;
      d0 = done_cnt6;
      if6.a_in  = a;
      if6.b_in  = b;
      if6.start = 1'b1;
      q6.push_back(exp);
      @(posedge clk); #1;
      if6.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("run6_busy", 32'(if6.busy), 32'd1);
         chk("run6_done_low", 32'(if6.done), 32'd0);
         chk("run6_sel", 32'({if6.sel_02, if6.sel_01, if6.sel_00}), 32'(k));
         chk("run6_op_a", 32'(if6.op_a), 32'(a));
         chk("run6_op_b", 32'(if6.op_b), 32'(b));
         if (disturb) begin
            if6.a_in  = ~if6.a_in;
            if6.b_in  = 1'($urandom_range(1));
            if6.start = (k % 2 == 0);
         end
         @(posedge clk); #1;
      end
      chk("done6_high", 32'(if6.done), 32'd1);
      chk("done6_busy_low", 32'(if6.busy), 32'd0);
      chk("done6_sel_zero", 32'({if6.sel_02, if6.sel_01, if6.sel_00}), 32'd0);
      if (disturb) begin
         if6.start = 1'b1;
         if6.a_in  = ~a;
         if6.b_in  = ~b;
      end
      @(posedge clk); #1;
      if6.start = 1'b0;
      chk("idle6_done_low", 32'(if6.done), 32'd0);
      chk("idle6_busy_low", 32'(if6.busy), 32'd0);
      @(posedge clk); #1;
      chk("idle6_no_restart", 32'(if6.busy), 32'd0);
      chk("idle6_op_a_held", 32'(if6.op_a), 32'(a));
      chk("idle6_op_b_held", 32'(if6.op_b), 32'(b));
      chk("done6_pulse_count", 32'(done_cnt6 - d0), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      if6.start = 1'b0; if6.a_in = 1'b0; if6.b_in = 1'b0;
      if8.start = 1'b0; if8.a_in = 1'b0; if8.b_in = 1'b0;

      // reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(if6.busy), 32'd0);
      chk("rst_done", 32'(if6.done), 32'd0);
      chk("rst_result", 32'(if6.result), 32'd0);
      chk("rst_sel", 32'({if6.sel_02, if6.sel_01, if6.sel_00}), 32'd0);
      chk("rst_op_a", 32'(if6.op_a), 32'd0);
      chk("rst_op_b", 32'(if6.op_b), 32'd0);
      chk("rst8_result", 32'(if8.result), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic sweep a=0,b=1
      sweep6(1'b0, 1'b1, 8'b0001_0110, 1'b0);

      // further operand pairs; result must hold while idle
      sweep6(1'b1, 1'b1, 8'b0010_0011, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle6_result_stable", 32'(if6.result), 32'b10_0011);
      sweep6(1'b1, 1'b0, 8'b0001_0110, 1'b0);
      sweep6(1'b0, 1'b0, 8'b0010_1100, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("idle6_result_stable2", 32'(if6.result), 32'b10_1100);

      // inputs wiggled during RUN and start held in DONE
      sweep6(1'b1, 1'b0, 8'b0001_0110, 1'b1);

      // reset asserted on the third RUN cycle aborts the sweep
      begin
         int d0;
         d0 = done_cnt6;
         if6.a_in = 1'b1; if6.b_in = 1'b1; if6.start = 1'b1;
         @(posedge clk); #1;
         if6.start = 1'b0;
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk("abort_pre_sel", 32'({if6.sel_02, if6.sel_01, if6.sel_00}), 32'd2);
         rst_n = 1'b0;
         #1;
         chk("abort_busy", 32'(if6.busy), 32'd0);
         chk("abort_done", 32'(if6.done), 32'd0);
         chk("abort_sel", 32'({if6.sel_02, if6.sel_01, if6.sel_00}), 32'd0);
         chk("abort_result", 32'(if6.result), 32'd0);
         chk("abort_op_a", 32'(if6.op_a), 32'd0);
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         repeat (8) @(posedge clk);
         #1;
         chk("abort_no_done", 32'(done_cnt6 - d0), 32'd0);
         chk("abort_stays_idle", 32'(if6.busy), 32'd0);
      end
      sweep6(1'b0, 1'b0, 8'b0010_1100, 1'b0);

      // 8-op instance reaches codes 6 and 7
      begin
         int d0;
         d0 = done_cnt8;
         if8.a_in = 1'b1; if8.b_in = 1'b1; if8.start = 1'b1;
         q8.push_back(8'b0010_0011);
         @(posedge clk); #1;
         if8.start = 1'b0;
         for (int k = 0; k < 8; k++) begin
            chk("run8_busy", 32'(if8.busy), 32'd1);
            chk("run8_sel", 32'({if8.sel_02, if8.sel_01, if8.sel_00}), 32'(k));
            chk("run8_done_low", 32'(if8.done), 32'd0);
            @(posedge clk); #1;
         end
         chk("done8_high", 32'(if8.done), 32'd1);
         chk("done8_busy_low", 32'(if8.busy), 32'd0);
         @(posedge clk); #1;
         chk("idle8_done_low", 32'(if8.done), 32'd0);
         chk("done8_pulse_count", 32'(done_cnt8 - d0), 32'd1);
      end

      repeat (2) @(posedge clk);
      #1;
      chk("sb6_drained", 32'(q6.size()), 32'd0);
      chk("sb8_drained", 32'(q8.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
